// File: rtl/i2c_target.sv
// I2C target with a byte-wide register-bank port; bits sampled on SCL rise, SDA changed on SCL fall.
// Optional macro I2C_TARGET_AUTOINC_EN: post-increment the pointer after each written or ACKed read byte.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int          REG_AW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdat,
    output logic              wr_stb,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        wr_data,
    input  logic [7:0]        rd_data,
    output logic              busy
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);
`endif

    logic [2:0]        scl_pipe_q, scl_pipe_d;
    logic [2:0]        sda_pipe_q, sda_pipe_d;
    logic [3:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              phase_q, phase_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_stb_q, wr_stb_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic [7:0]        rx_byte;
    logic              sda_in;
    logic              scl_s, scl_h, sda_s, sda_h;
    logic              scl_rise, scl_fall, bus_start, bus_stop;

    assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in   = i2c_sdat;

    // [0],[1] form the synchroniser, [2] is the history flop for edge detection
    assign scl_s     = scl_pipe_q[1];
    assign scl_h     = scl_pipe_q[2];
    assign sda_s     = sda_pipe_q[1];
    assign sda_h     = sda_pipe_q[2];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign bus_start = scl_s & scl_h & sda_h & ~sda_s;
    assign bus_stop  = scl_s & scl_h & ~sda_h & sda_s;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], i2c_sclk};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        wr_stb_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        rx_byte    = {shift_q, sda_s};
`ifdef I2C_TARGET_AUTOINC_EN
        if (wr_stb_q) begin
            reg_addr_d = reg_addr_q + PTR_ONE;
        end
`endif
        if (bus_start || bus_stop) begin
            state_d  = bus_start ? S_ADDR : S_IDLE;
            cnt_d    = 3'd0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == S_ADDR) begin
                                rw_d    = rx_byte[0];
                                state_d = (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end else if (state_q == S_REG) begin
                                reg_addr_d = rx_byte[REG_AW-1:0];
                                state_d    = S_REG_ACK;
                            end else begin
                                wr_data_d = rx_byte;
                                wr_stb_d  = 1'b1;
                                state_d   = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // first fall starts the ACK pulse, second fall ends it
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d  = S_RDATA;
                                shift_d  = rd_data[6:0];
                                sda_oe_d = ~rd_data[7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_REG;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        shift_d  = {shift_q[5:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = S_RDATA_ACK;
                        end
                    end
                end
                // phase_q marks that the initiator ACK has been sampled
                S_RDATA_ACK: begin
                    if (scl_fall && !phase_q) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_s) begin
                            phase_d = 1'b1;
`ifdef I2C_TARGET_AUTOINC_EN
                            reg_addr_d = reg_addr_q + PTR_ONE;
`endif
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall) begin
                        state_d  = S_RDATA;
                        phase_d  = 1'b0;
                        shift_d  = rd_data[6:0];
                        sda_oe_d = ~rd_data[7];
                    end
                end
                S_IGNORE: sda_oe_d = 1'b0;
                default:  ;
            endcase
        end
        if (state_d == S_IDLE || state_d == S_IGNORE) begin
            busy_d = 1'b0;
        end else if (state_d == S_ADDR_ACK) begin
            busy_d = 1'b1;
        end else begin
            busy_d = busy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 7'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            wr_stb_q   <= wr_stb_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_stb   = wr_stb_q;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged initiator plus write/read scoreboards.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 40;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda_bus;
    logic       wr_stb;
    logic [3:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] bank [16];
    logic [11:0] wq [$];
    logic [7:0]  rq [$];
    int checks = 0;
    int errors = 0;
    int tgt_low_cnt = 0;
    int busy_cnt = 0;
    int lc0, bc0;

    always #5 clk = ~clk;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign rd_data = bank[reg_addr];

    i2c_target #(.DEV_ADDR(7'h1A), .REG_AW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i2c_sclk (scl),
        .i2c_sdat (sda_bus),
        .wr_stb   (wr_stb),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // write scoreboard: every strobe pops one expected {addr, data}
    always @(negedge clk) begin
        if (wr_stb) begin
            logic [11:0] e;
            e = (wq.size() != 0) ? wq.pop_front() : 12'hxxx;
            $display("wr_stb addr=%0d data=0x%02h", reg_addr, wr_data);
            check("wr_stb", {20'd0, reg_addr, wr_data}, {20'd0, e});
        end
        if (sda_bus === 1'b0 && !m_low) tgt_low_cnt <= tgt_low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic bit_w(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic bit_r(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) bit_w(b[i]);
        bit_r(a);
        $display("send byte 0x%02h ack_bit=%0b", b, a);
        check(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(input logic ack_it, input string tag);
        logic [7:0] d;
        logic [7:0] e;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        e = (rq.size() != 0) ? rq.pop_front() : 8'hxx;
        $display("recv byte 0x%02h ack=%0b", d, ack_it);
        check(tag, {24'd0, d}, {24'd0, e});
        bit_w(~ack_it);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 8'h00;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_stb", {31'd0, wr_stb}, 0);
        check("rst_reg_addr", {28'd0, reg_addr}, 0);
        check("rst_wr_data", {24'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_sda", {31'd0, sda_bus}, 1);

        // single write to register 5
        i2c_start;
        send_byte(8'h34, 1'b0, "w1_addr_ack");
        check("w1_busy", {31'd0, busy}, 1);
        send_byte(8'h05, 1'b0, "w1_reg_ack");
        wq.push_back({4'h5, 8'hA7});
        send_byte(8'hA7, 1'b0, "w1_data_ack");
        i2c_stop;
        repeat (6) @(negedge clk);
        check("w1_busy_after_stop", {31'd0, busy}, 0);

        // address mismatch: never ACKed, never busy
        lc0 = tgt_low_cnt; bc0 = busy_cnt;
        i2c_start;
        send_byte(8'h36, 1'b1, "nm_addr_nack");
        send_byte(8'h00, 1'b1, "nm_data_nack");
        i2c_stop;
        repeat (6) @(negedge clk);
        check("nm_sda_low", tgt_low_cnt - lc0, 0);
        check("nm_busy", busy_cnt - bc0, 0);

        // pointer write, repeated START, two-byte read ending in NACK
        bank[3] = 8'h5C; bank[4] = 8'h81;
        i2c_start;
        send_byte(8'h34, 1'b0, "pr_addr_w_ack");
        send_byte(8'h03, 1'b0, "pr_reg_ack");
        i2c_start;
        send_byte(8'h35, 1'b0, "pr_addr_r_ack");
        rq.push_back(8'h5C);
        rq.push_back(AUTOINC ? 8'h81 : 8'h5C);
        recv_byte(1'b1, "pr_rd_byte0");
        recv_byte(1'b0, "pr_rd_byte1");
        check("pr_busy_after_nack", {31'd0, busy}, 0);
        lc0 = tgt_low_cnt;
        rq.push_back(8'hFF);
        recv_byte(1'b0, "pr_released_byte");
        check("pr_sda_after_nack", tgt_low_cnt - lc0, 0);
        i2c_stop;

        // burst write across the top of the bank
        i2c_start;
        send_byte(8'h34, 1'b0, "bw_addr_ack");
        send_byte(8'h0F, 1'b0, "bw_reg_ack");
        wq.push_back({4'hF, 8'h11});
        send_byte(8'h11, 1'b0, "bw_data0_ack");
        wq.push_back({(AUTOINC ? 4'h0 : 4'hF), 8'h22});
        send_byte(8'h22, 1'b0, "bw_data1_ack");
        i2c_stop;

        // STOP after four bits of a data byte, then a normal write
        i2c_start;
        send_byte(8'h34, 1'b0, "ab_addr_ack");
        send_byte(8'h02, 1'b0, "ab_reg_ack");
        bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b0);
        i2c_stop;
        repeat (6) @(negedge clk);
        check("ab_busy", {31'd0, busy}, 0);
        check("ab_sda", {31'd0, sda_bus}, 1);
        i2c_start;
        send_byte(8'h34, 1'b0, "ab2_addr_ack");
        send_byte(8'h07, 1'b0, "ab2_reg_ack");
        wq.push_back({4'h7, 8'h99});
        send_byte(8'h99, 1'b0, "ab2_data_ack");
        i2c_stop;

        // reset pulse while the address ACK is on the bus
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_w(((8'h34 >> i) & 8'h01) != 0);
        m_low = 1'b0; #Q; scl = 1'b1; #Q;
        check("ra_ack_driven", {31'd0, sda_bus}, 0);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("ra_sda_released", {31'd0, sda_bus}, 1);
        check("ra_wr_stb", {31'd0, wr_stb}, 0);
        check("ra_reg_addr", {28'd0, reg_addr}, 0);
        check("ra_wr_data", {24'd0, wr_data}, 0);
        check("ra_busy", {31'd0, busy}, 0);
        #Q; scl = 1'b0; #Q;
        i2c_stop;
        repeat (6) @(negedge clk);
        i2c_start;
        send_byte(8'h34, 1'b0, "ra2_addr_ack");
        send_byte(8'h01, 1'b0, "ra2_reg_ack");
        wq.push_back({4'h1, 8'h42});
        send_byte(8'h42, 1'b0, "ra2_data_ack");
        i2c_stop;

        repeat (20) @(negedge clk);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
